// File: rtl/param_instruction_cache.sv
// Direct-mapped instruction cache with a miss/refill FSM and a req/ack refill port.
// Latency: hit returns 1 cycle after request; miss returns (cycles to mem_ack) + 2.
// Backpressure: stall holds fetch during a refill. Optional ICACHE_STATS_EN adds hit/miss counters.
module param_instruction_cache #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic                             flush,
  output logic [WORD_W-1:0]                instr_out,
  output logic                             instr_valid,
  output logic                             hit,
  output logic                             stall,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_ack,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_line
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int OFF_W   = $clog2(WORD_W / 8);
  localparam int WSEL_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int LO_W    = OFF_W + WSEL_W;
  localparam int TAG_LSB = LO_W + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int LINE_W  = WORD_W * WORDS_PER_LINE;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  // Address fields are extracted by shifting so a zero-width byte offset needs no special case.
  function automatic logic [WSEL_W-1:0] wsel_of(input logic [ADDR_W-1:0] a);
    return WSEL_W'(a >> OFF_W);
  endfunction
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> LO_W);
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> TAG_LSB);
  endfunction
  function automatic logic [ADDR_W-1:0] align_of(input logic [ADDR_W-1:0] a);
    return (a >> LO_W) << LO_W;
  endfunction
  // Word 0 sits in the MSBs of a line.
  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [WSEL_W-1:0] ws);
    logic [LINE_W-1:0] sh;
    sh = line << (ws * WORD_W);
    return sh[LINE_W-1 -: WORD_W];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] instr_out_q, instr_out_d;
  logic              instr_valid_q, instr_valid_d;
  logic              hit_q, hit_d;
  logic              stall_q, stall_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              flush_pending_q, flush_pending_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic              fill_en;
  logic              hit_inc, miss_inc;
  logic              lookup_hit;

  assign lookup_hit = valid_q[idx_of(req_addr)] && (tag_q[idx_of(req_addr)] == tag_of(req_addr));

  // Next-state logic for lookup, refill handshake, response and flush handling.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    instr_out_d     = instr_out_q;
    instr_valid_d   = 1'b0;
    hit_d           = 1'b0;
    stall_d         = stall_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    flush_pending_d = flush_pending_q;
    valid_d         = valid_q;
    fill_en         = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    case (state_q)
      S_IDLE: begin
        flush_pending_d = 1'b0;
        if (req_valid) begin
          // A flush in the same cycle forces a miss, since the line is about to be invalidated.
          if (lookup_hit && !flush) begin
            instr_out_d   = word_of(data_q[idx_of(req_addr)], wsel_of(req_addr));
            instr_valid_d = 1'b1;
            hit_d         = 1'b1;
            hit_inc       = 1'b1;
          end else begin
            miss_inc   = 1'b1;
            stall_d    = 1'b1;
            mem_req_d  = 1'b1;
            mem_addr_d = align_of(req_addr);
            addr_d     = req_addr;
            state_d    = S_FETCH;
          end
        end
        if (flush) valid_d = '0;
      end
      S_FETCH: begin
        if (flush) flush_pending_d = 1'b1;
        if (mem_ack) begin
          fill_en                 = 1'b1;
          valid_d[idx_of(addr_q)] = 1'b1;
          mem_req_d               = 1'b0;
          state_d                 = S_RESPOND;
        end
      end
      S_RESPOND: begin
        instr_out_d     = word_of(data_q[idx_of(addr_q)], wsel_of(addr_q));
        instr_valid_d   = 1'b1;
        stall_d         = 1'b0;
        state_d         = S_IDLE;
        // A deferred flush also drops the line just filled; the word is still delivered.
        if (flush_pending_q || flush) valid_d = '0;
        flush_pending_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any refill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      instr_out_q     <= '0;
      instr_valid_q   <= 1'b0;
      hit_q           <= 1'b0;
      stall_q         <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      instr_out_q     <= instr_out_d;
      instr_valid_q   <= instr_valid_d;
      hit_q           <= hit_d;
      stall_q         <= stall_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx_of(addr_q)]  <= tag_of(addr_q);
      data_q[idx_of(addr_q)] <= mem_line;
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign hit         = hit_q;
  assign stall       = stall_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Lookup counters wrap naturally; only reset clears them.
  always_comb begin
    hit_count_d  = hit_count_q + (hit_inc ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q + (miss_inc ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_param_instruction_cache.sv
// Scoreboard bench: stimulus pushes expected {hit, instr}; a monitor pops on instr_valid.
// Refill memory is driven directly by the stimulus with hand-computed line contents.
// Handshake signals (stall, mem_req, mem_addr) are checked inline at each step.
module tb_param_instruction_cache;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_line;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int tests  = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  localparam logic [63:0] L1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] L2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] L3 = 64'h5555_6666_7777_8888;

  param_instruction_cache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .instr_out(instr_out), .instr_valid(instr_valid), .hit(hit), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_line(mem_line)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered word must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_instr: got 0x%0h with nothing expected", instr_out);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("instr_out", {16'h0, instr_out}, {16'h0, e[15:0]});
          check("hit_flag", {31'h0, hit}, {31'h0, e[16]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch. On a miss, mem_ack is returned two cycles after mem_req rises.
  task automatic fetch(input logic [15:0] addr, input logic exp_hit, input logic [15:0] exp_instr,
                       input logic [63:0] line, input logic [15:0] exp_maddr,
                       input logic fl_req, input logic fl_fetch);
    exp_q.push_back({exp_hit, exp_instr});
    req_valid = 1'b1;
    req_addr  = addr;
    flush     = fl_req;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    if (exp_hit) begin
      check("hit_no_mem_req", {31'h0, mem_req}, 32'h0);
      check("hit_no_stall", {31'h0, stall}, 32'h0);
    end else begin
      check("miss_stall", {31'h0, stall}, 32'h1);
      check("miss_mem_req", {31'h0, mem_req}, 32'h1);
      check("miss_mem_addr", {16'h0, mem_addr}, {16'h0, exp_maddr});
      check("miss_no_valid", {31'h0, instr_valid}, 32'h0);
      flush = fl_fetch;
      step();
      flush = 1'b0;
      check("fetch_hold_req", {31'h0, mem_req}, 32'h1);
      check("fetch_hold_addr", {16'h0, mem_addr}, {16'h0, exp_maddr});
      mem_ack  = 1'b1;
      mem_line = line;
      step();
      mem_ack = 1'b0;
      check("respond_req_low", {31'h0, mem_req}, 32'h0);
      check("respond_stall", {31'h0, stall}, 32'h1);
      step();
      check("done_stall_low", {31'h0, stall}, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_line = '0;
    #12;
    check("rst_instr_out", {16'h0, instr_out}, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_hit", {31'h0, hit}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Cold miss, then hit on another word of the same line.
    fetch(16'h0048, 1'b0, 16'h1111, L1, 16'h0048, 1'b0, 1'b0);
    fetch(16'h004E, 1'b1, 16'h4444, '0, '0, 1'b0, 1'b0);
    fetch(16'h004A, 1'b1, 16'h2222, '0, '0, 1'b0, 1'b0);
    // Conflict on index 1 evicts the first line.
    fetch(16'h0448, 1'b0, 16'hAAAA, L2, 16'h0448, 1'b0, 1'b0);
    fetch(16'h044C, 1'b1, 16'hCCCC, '0, '0, 1'b0, 1'b0);
    fetch(16'h0048, 1'b0, 16'h1111, L1, 16'h0048, 1'b0, 1'b0);
    // Flush in IDLE, then the same address misses.
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch(16'h004C, 1'b0, 16'h3333, L1, 16'h0048, 1'b0, 1'b0);
    // Flush together with a request that would otherwise hit.
    fetch(16'h0046, 1'b0, 16'h4444, L1, 16'h0040, 1'b0, 1'b0);
    fetch(16'h0046, 1'b0, 16'h4444, L1, 16'h0040, 1'b1, 1'b0);
    fetch(16'h0042, 1'b1, 16'h2222, '0, '0, 1'b0, 1'b0);
    // Flush during FETCH: word still delivered, line not retained.
    fetch(16'h0010, 1'b0, 16'h5555, L3, 16'h0010, 1'b0, 1'b1);
    fetch(16'h0012, 1'b0, 16'h6666, L3, 16'h0010, 1'b0, 1'b0);
    fetch(16'h0014, 1'b1, 16'h7777, '0, '0, 1'b0, 1'b0);

    // Reset during a refill aborts it; a late ack is ignored.
    req_valid = 1'b1;
    req_addr  = 16'h0448;
    step();
    req_valid = 1'b0;
    check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    check("rst_mid_valid", {31'h0, instr_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_line = L2;
    step();
    mem_ack = 1'b0;
    step();
    check("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
    check("late_ack_stall", {31'h0, stall}, 32'h0);
    fetch(16'h0448, 1'b0, 16'hAAAA, L2, 16'h0448, 1'b0, 1'b0);
    fetch(16'h044A, 1'b1, 16'hBBBB, '0, '0, 1'b0, 1'b0);
    fetch(16'h044E, 1'b1, 16'hDDDD, '0, '0, 1'b0, 1'b0);
    fetch(16'h0010, 1'b0, 16'h5555, L3, 16'h0010, 1'b0, 1'b0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'd2);
    check("miss_count", miss_count, 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("hit_count_flush", hit_count, 32'd2);
    check("miss_count_flush", miss_count, 32'd2);
`endif

    repeat (3) step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
